// File: rtl/burst_sequencer_if.sv
// Handshake and status bundle for burst_sequencer.
// The master side drives requests and bounds; the slave side reports progress.
`timescale 1ns/1ps
interface burst_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             enable;
    logic             abort;
    logic             cont;
    logic [CNT_W-1:0] n_max;
    logic [CNT_W-1:0] m_max;
    logic             out;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] n_count;
    logic [CNT_W-1:0] m_count;

    modport master (
        output start, enable, abort, cont, n_max, m_max,
        input  out, done, busy, n_count, m_count
    );

    modport slave (
        input  start, enable, abort, cont, n_max, m_max,
        output out, done, busy, n_count, m_count
    );
endinterface

// File: rtl/burst_sequencer.sv
// Two-level loop sequencer: m_max rows of n_max out-high cycles, one gap cycle
// after each row, then a single done strobe (optionally repeating).
`timescale 1ns/1ps
module burst_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    burst_sequencer_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] n_count;
    logic [CNT_W-1:0] m_count;
    logic [CNT_W-1:0] n_max_r;
    logic [CNT_W-1:0] m_max_r;
    logic             cont_r;

    // Abort has priority over every state transition and start request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            n_count <= ZERO;
            m_count <= ZERO;
            n_max_r <= ZERO;
            m_max_r <= ZERO;
            cont_r  <= 1'b0;
        end else if (bus.abort) begin
            state   <= IDLE;
            n_count <= ZERO;
            m_count <= ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_max_r <= bus.n_max;
                        m_max_r <= bus.m_max;
                        cont_r  <= bus.cont;
                        n_count <= ZERO;
                        m_count <= ZERO;
                        if (bus.n_max == ZERO || bus.m_max == ZERO) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        if (n_count == n_max_r - ONE) begin
                            n_count <= ZERO;
                            state   <= GAP;
                        end else begin
                            n_count <= n_count + ONE;
                        end
                    end
                end
                GAP: begin
                    n_count <= ZERO;
                    if (m_count == m_max_r - ONE) begin
                        state <= DONE;
                    end else begin
                        m_count <= m_count + ONE;
                        state   <= RUN;
                    end
                end
                DONE: begin
                    n_count <= ZERO;
                    m_count <= ZERO;
                    // Zero bounds in continuous mode would otherwise spin on done.
                    if (cont_r && n_max_r != ZERO && m_max_r != ZERO) begin
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out     = (state == RUN) && bus.enable;
    assign bus.done    = (state == DONE);
    assign bus.busy    = (state != IDLE);
    assign bus.n_count = n_count;
    assign bus.m_count = m_count;
endmodule
